// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-write signal bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_rd_fire;
    logic                          wr_ready;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    // Arbiter side
    modport master (
        input  req_valid, req_data, fifo_rd_fire, wr_ready,
        output req_ready, wr_en, wr_data, grant, busy
    );

    // Requesters and FIFO side
    modport slave (
        output req_valid, req_data, fifo_rd_fire, wr_ready,
        input  req_ready, wr_en, wr_data, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port (option macro: FIFO_WR_ARB_PRIO0_EN)
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int BEAT_W     = $clog2(BURST_LEN) + 1
) (
    input  logic                clk,
    input  logic                reset,
    fifo_wr_arbiter_if.master   bus
);
    localparam logic [0:0]        S_IDLE    = 1'b0;
    localparam logic [0:0]        S_GRANT   = 1'b1;
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [0:0]           r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_gnt_id;
    logic [BEAT_W-1:0]    r_beats;
    logic [NUM_REQ-1:0]   r_grant;

    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic                 w_in_grant;
    logic                 w_gnt_valid;
    logic                 w_slot_open;
    logic                 w_accept;
    logic [ID_W-1:0]      w_next_ptr;
    logic                 w_ptr_upd;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Requester index base+offs, wrapped into 0..NUM_REQ-1
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    assign w_in_grant  = (r_state == S_GRANT);
    assign w_gnt_valid = bus.req_valid[r_gnt_id];
    // A read in the same cycle takes the FIFO, so the write slot is closed
    assign w_slot_open = w_in_grant & bus.wr_ready & ~bus.fifo_rd_fire;
    assign w_accept    = w_slot_open & w_gnt_valid;
    assign w_next_ptr  = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;

`ifdef FIFO_WR_ARB_PRIO0_EN
    // Requester 0 wins outside the rotation, so its releases leave the pointer alone
    assign w_ptr_upd = (r_gnt_id != '0);
`else
    assign w_ptr_upd = 1'b1;
`endif

    // Pick the first valid requester at or after the round-robin pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rr_index(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_index(r_rr_ptr, k);
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
        end
`endif
    end

    // Route the owner's data slice to the FIFO write port
    always_comb begin
        w_wr_data = bus.req_data[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt_id == ID_W'(i)) w_wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Grant/burst state machine; a beat counts only when the write lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_beats  <= '0;
            r_grant  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_state  <= S_GRANT;
                r_gnt_id <= w_winner;
                r_grant  <= onehot(w_winner);
                r_beats  <= '0;
            end
        end else begin
            if (!w_gnt_valid || (w_accept && r_beats == LAST_BEAT)) begin
                r_state <= S_IDLE;
                r_grant <= '0;
                if (w_ptr_upd) r_rr_ptr <= w_next_ptr;
            end else if (w_accept) begin
                r_beats <= r_beats + 1'b1;
            end
        end
    end

    assign bus.wr_en     = w_accept;
    assign bus.wr_data   = w_wr_data;
    assign bus.req_ready = r_grant & {NUM_REQ{w_slot_open}};
    assign bus.grant     = r_grant;
    assign bus.busy      = w_in_grant;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] src_q [NR][$];
    logic [DW-1:0] exp_wr_q [$];
    int            exp_gnt_q [$];
    int            wr_cyc_q [$];
    logic [NR-1:0] prev_gnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]           = (src_q[i].size() > 0);
            bus.req_data[i*DW +: DW]   = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic push_src(input int r, input logic [DW-1:0] d);
        src_q[r].push_back(d);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (bus.grant == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_granted"}, 32'(bus.grant != '0), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while ((exp_wr_q.size() != 0 || src_busy()) && n < bound) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drained"}, 32'(exp_wr_q.size()), 32'd0);
        check({tag, "_grants_seen"}, 32'(exp_gnt_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_grant_clear"}, 32'(bus.grant), 32'd0);
    endtask

    task automatic check_gaps(input string tag, input int n_exp, input int gap0, input int gap1);
        check({tag, "_nwrites"}, 32'(wr_cyc_q.size()), 32'(n_exp));
        if (wr_cyc_q.size() == n_exp) begin
            for (int i = 1; i < n_exp; i++)
                check({tag, "_gap"}, 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'((i % 2 == 1) ? gap0 : gap1));
        end
    endtask

    // Requester model: hold each word until it is accepted at a clock edge
    initial begin : producer
        logic [NR-1:0] fire;
        drive_reqs();
        forever begin
            @(negedge clk);
            fire = bus.req_ready & bus.req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++)
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            drive_reqs();
        end
    end

    // Output monitor: compare FIFO writes and new grants against the scoreboard
    initial begin : monitor
        logic [DW-1:0] e;
        int            g;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.wr_en) begin
                wr_cyc_q.push_back(cyc);
                check("ready_matches_grant", 32'(bus.req_ready), 32'(bus.grant));
                check("write_expected", 32'(exp_wr_q.size() > 0), 32'd1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    check("wr_data", 32'(bus.wr_data), 32'(e));
                end
            end
            if (bus.grant != '0 && prev_gnt == '0) begin
                check("grant_expected", 32'(exp_gnt_q.size() > 0), 32'd1);
                if (exp_gnt_q.size() > 0) begin
                    g = exp_gnt_q.pop_front();
                    check("grant", 32'(bus.grant), 32'(1 << g));
                end
            end
            prev_gnt = bus.grant;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.wr_ready     = 1'b1;
        bus.fifo_rd_fire = 1'b0;
        #1 reset = 1'b0;

        // Test 1: all requesters valid through reset, 2-beat bursts in rotation
`ifdef FIFO_WR_ARB_PRIO0_EN
        exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(0);
        for (int k = 0; k < 4; k++) exp_wr_q.push_back(8'(k));
        for (int p = 0; p < 2; p++)
            for (int i = 1; i < NR; i++) begin
                exp_gnt_q.push_back(i);
                for (int k = 2*p; k < 2*p + 2; k++) exp_wr_q.push_back(8'(i*16 + k));
            end
`else
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NR; i++) begin
                exp_gnt_q.push_back(i);
                for (int k = 2*p; k < 2*p + 2; k++) exp_wr_q.push_back(8'(i*16 + k));
            end
`endif
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 4; k++) push_src(i, 8'(i*16 + k));
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t1_first_grant", 32'(bus.grant), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_drain("t1", 200);

        // Test 2: requester 2 alone, five words, bubble after each burst
        wr_cyc_q.delete();
        for (int k = 0; k < 3; k++) exp_gnt_q.push_back(2);
        for (int k = 0; k < 5; k++) begin
            push_src(2, 8'(8'hA0 + k));
            exp_wr_q.push_back(8'(8'hA0 + k));
        end
        wait_drain("t2", 100);
        check_gaps("t2", 5, 1, 2);

        // Test 3: FIFO full stalls the granted requester without losing the beat
        bus.wr_ready = 1'b0;
        wr_cyc_q.delete();
        exp_gnt_q.push_back(1);
        push_src(1, 8'hB0); exp_wr_q.push_back(8'hB0);
        push_src(1, 8'hB1); exp_wr_q.push_back(8'hB1);
        wait_grant("t3");
        for (int s = 0; s < 3; s++) begin
            check("t3_stall_wr_en", 32'(bus.wr_en), 32'd0);
            check("t3_stall_ready", 32'(bus.req_ready), 32'd0);
            check("t3_stall_grant", 32'(bus.grant), 32'h2);
            if (s < 2) @(negedge clk);
        end
        @(posedge clk);
        #2 bus.wr_ready = 1'b1;
        wait_drain("t3", 50);
        check_gaps("t3", 2, 1, 1);

        // Test 6: pointer at 2 with requesters 0 and 2 valid
        push_src(0, 8'h60);
        push_src(2, 8'h62);
`ifdef FIFO_WR_ARB_PRIO0_EN
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
        exp_wr_q.push_back(8'h60); exp_wr_q.push_back(8'h62);
`else
        exp_gnt_q.push_back(2); exp_gnt_q.push_back(0);
        exp_wr_q.push_back(8'h62); exp_wr_q.push_back(8'h60);
`endif
        wait_drain("t6", 50);

        // Test 4: read collision blocks the write and the beat is not counted
        bus.fifo_rd_fire = 1'b1;
        wr_cyc_q.delete();
        exp_gnt_q.push_back(3);
        push_src(3, 8'hC0); exp_wr_q.push_back(8'hC0);
        push_src(3, 8'hC1); exp_wr_q.push_back(8'hC1);
        wait_grant("t4");
        check("t4_coll_wr_en", 32'(bus.wr_en), 32'd0);
        check("t4_coll_ready", 32'(bus.req_ready), 32'd0);
        check("t4_coll_grant", 32'(bus.grant), 32'h8);
        @(posedge clk);
        #2 bus.fifo_rd_fire = 1'b0;
        wait_drain("t4", 50);
        check_gaps("t4", 2, 1, 1);

        // Test 5: reset in the middle of a burst, arbitration restarts at 0
        exp_gnt_q.push_back(1);
        push_src(1, 8'hD0); exp_wr_q.push_back(8'hD0);
        push_src(1, 8'hD1);
        push_src(1, 8'hD2);
        wait_grant("t5");
        check("t5_first_beat", 32'(bus.wr_en), 32'd1);
        @(posedge clk);
        #2;
        push_src(0, 8'hE0);
        push_src(3, 8'h3A);
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(3);
        exp_wr_q.push_back(8'hE0); exp_wr_q.push_back(8'hD1);
        exp_wr_q.push_back(8'hD2); exp_wr_q.push_back(8'h3A);
        reset = 1'b0;
        #1;
        check("t5_rst_grant", 32'(bus.grant), 32'd0);
        check("t5_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_grant("t5_after");
        check("t5_restart_grant", 32'(bus.grant), 32'h1);
        wait_drain("t5", 100);

        check("final_wr_queue", 32'(exp_wr_q.size()), 32'd0);
        check("final_gnt_queue", 32'(exp_gnt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's fifo block between NUM_REQ producers.
It grants one requester at a time for a burst of up to BURST_LEN beats and forwards that requester's data to the FIFO write port.
The downstream FIFO services a read in preference to a write in the same cycle, so the arbiter counts a beat only when the write actually lands.
It sits directly in front of fifo (wr_en/wr_data/wr_ready) and is fed the FIFO's read-fire signal.

Parameters:
- DATA_WIDTH, 8, width of each requester's data and of wr_data.
- NUM_REQ, 4, number of requesters (>= 2).
- BURST_LEN, 4, max beats per grant (>= 1).
- ID_W, $clog2(NUM_REQ), width of the grant index.
- BEAT_W, $clog2(BURST_LEN)+1, width of the beat counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- fifo_rd_fire  in  1  FIFO rd_en & rd_val this cycle
- wr_ready  in  1  FIFO not full
- wr_en  out  1  FIFO write strobe
- wr_data  out  DATA_WIDTH  FIFO write data
- grant  out  NUM_REQ  registered one-hot owner; 0 when idle
- busy  out  1  1 while in GRANT

Behaviour:
- States: IDLE, GRANT. All state is registered. Asynchronous reset (reset == 0) forces:
  - state = IDLE, rr_ptr = 0, gnt_id = 0, beats = 0, grant = 0.
  - Combinational outputs settle to 0 (req_ready = 0, wr_en = 0, busy = 0).
- IDLE arbitration:
  - Scan req_valid from rr_ptr upward, wrapping at NUM_REQ-1 -> 0. The first set bit wins.
  - Next edge: gnt_id = winner, grant = onehot(winner), beats = 0, state = GRANT.
  - If no request is valid, stay in IDLE.
  - Arbitration latency: 1 cycle from req_valid to the grant being visible.
- accept = (state == GRANT) & req_valid[gnt_id] & wr_ready & ~fifo_rd_fire.
- wr_en = accept.
- wr_data = req_data slice gnt_id, always driven; don't-care when wr_en = 0.
- req_ready[gnt_id] = (state == GRANT) & wr_ready & ~fifo_rd_fire. All other bits are 0.
  - The requester may not withdraw valid while ready is low.
- GRANT transitions:
  - On accept with beats == BURST_LEN-1: go to IDLE and set rr_ptr = (gnt_id+1) mod NUM_REQ (burst complete).
  - On accept otherwise: beats + 1.
  - req_valid[gnt_id] == 0: go to IDLE and set rr_ptr = (gnt_id+1) mod NUM_REQ (requester drained; early release).
  - Valid high but no accept (full, or read collision): hold state and beats; no timeout.
- On every GRANT -> IDLE transition, grant clears to 0. The following cycle is an arbitration bubble, so there is at most one grant per 2 cycles when bursts are 1 beat.
- Wrap: the rr_ptr increment wraps NUM_REQ-1 -> 0 and never indexes past NUM_REQ-1.
- Reset mid-burst: beats are abandoned and nothing is written in the reset cycle. After release, arbitration restarts at requester 0.
- Fairness: under continuous requests from all requesters, each receives one grant every NUM_REQ grants.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO0_EN.
- Defined:
  - In IDLE, requester 0 wins whenever req_valid[0] = 1, regardless of rr_ptr.
  - Other requesters arbitrate round-robin as above.
  - rr_ptr is updated only on release of a non-zero gnt_id.
- Undefined: pure round-robin; requester 0 has no special treatment.

Test Plan:
1. Reset low with all req_valid = 1111, then release reset -> grant = 0001 one cycle after reset deasserts; bursts of 2 beats each are granted in order 0, 1, 2, 3, 0 (NUM_REQ = 4, BURST_LEN = 2).
2. Requester 2 alone, 5 words A0..A4, wr_ready = 1 -> writes A0, A1, bubble, A2, A3, bubble, A4; grant drops to 0 once valid goes low.
3. Granted requester 1 with wr_ready = 0 for 3 cycles -> wr_en = 0, req_ready = 0, beats held; the word written after wr_ready rises is the same data.
4. fifo_rd_fire = 1 on a cycle with valid & wr_ready -> wr_en = 0 and the beat is not counted; the word is written the next cycle when fifo_rd_fire = 0.
5. Reset asserted mid-burst (beats = 1) -> grant = 0 and wr_en = 0 immediately; after release, arbitration restarts at requester 0.
6. With FIFO_WR_ARB_PRIO0_EN defined, rr_ptr = 2 and req_valid = 0101 -> requester 0 is granted; without the macro, requester 2 is granted.
